// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL lock sequencer: state encoding, default
// timing parameters and counter sizing helpers.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAIL
  } state_e;

  localparam int unsigned DEF_RST_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 50000;
  localparam int unsigned DEF_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_MAX_RETRY     = 3;

  localparam int unsigned RETRY_W = 2;
  localparam int unsigned LOST_W  = 8;

  // Width needed to hold the values 0 .. n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/pll_lock_ctrl_if.sv
// Signals exchanged between the lock sequencer and the PLL / top level.
interface pll_lock_ctrl_if;
  import pll_ctrl_pkg::*;

  logic               locked;
  logic               pll_areset;
  logic               rst_n_out;
  logic               lock_ok;
  logic               pll_fail;
  logic [RETRY_W-1:0] retry_cnt;
  logic [LOST_W-1:0]  lost_cnt;

  modport master (
    input  locked,
    output pll_areset,
    output rst_n_out,
    output lock_ok,
    output pll_fail,
    output retry_cnt,
    output lost_cnt
  );

  modport slave (
    output locked,
    input  pll_areset,
    input  rst_n_out,
    input  lock_ok,
    input  pll_fail,
    input  retry_cnt,
    input  lost_cnt
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous status bit, resets to 0.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL bring-up sequencer: reset pulse, lock wait with bounded retries,
// lock qualification, run monitoring and sticky failure.
module pll_lock_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned MAX_RETRY     = DEF_MAX_RETRY
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  pll_lock_ctrl_if.master  pll
);

  localparam int unsigned CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned CNT_W   = cnt_width(CNT_MAX);

  localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STB_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [LOST_W-1:0]  lost_q, lost_d;
  logic               areset_q, areset_d;
  logic               rst_n_out_q, rst_n_out_d;
  logic               lock_ok_q, lock_ok_d;
  logic               fail_q, fail_d;
  logic               locked_s;

  sync_2ff u_lock_sync (
    .clk_i  (sys_clk),
    .rst_ni (sys_rst_n),
    .d_i    (pll.locked),
    .q_o    (locked_s)
  );

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    lost_d  = lost_q;

    unique case (state_q)
      ST_RESET: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // A lock seen on the timeout cycle takes priority over a retry.
        if (locked_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TMO_LAST) begin
          if (retry_q == RETRY_LIM) begin
            state_d = ST_FAIL;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = ST_RESET;
          end
        end
      end
      ST_STABLE: begin
        if (!locked_s)              state_d = ST_WAIT_LOCK;
        else if (cnt_q == STB_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d = ST_RESET;
          if (lost_q != '1) lost_d = lost_q + 1'b1;
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase

    if (state_d == ST_RUN) retry_d = '0;

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == ST_RESET || state_q == ST_WAIT_LOCK ||
                 state_q == ST_STABLE) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end

    // Outputs are decoded from the next state so they move with the state.
    areset_d    = (state_d == ST_RESET) || (state_d == ST_FAIL);
    rst_n_out_d = (state_d == ST_RUN);
    lock_ok_d   = (state_d == ST_RUN);
    fail_d      = (state_d == ST_FAIL);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_RESET;
      cnt_q       <= '0;
      retry_q     <= '0;
      lost_q      <= '0;
      areset_q    <= 1'b1;
      rst_n_out_q <= 1'b0;
      lock_ok_q   <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lost_q      <= lost_d;
      areset_q    <= areset_d;
      rst_n_out_q <= rst_n_out_d;
      lock_ok_q   <= lock_ok_d;
      fail_q      <= fail_d;
    end
  end

  assign pll.pll_areset = areset_q;
  assign pll.rst_n_out  = rst_n_out_q;
  assign pll.lock_ok    = lock_ok_q;
  assign pll.pll_fail   = fail_q;
  assign pll.retry_cnt  = retry_q;
  assign pll.lost_cnt   = lost_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed vector bench for pll_lock_ctrl with short timing parameters.
module tb_pll_lock_ctrl;

  typedef struct {
    bit          do_rst;
    logic        lk;
    int unsigned n;
    logic [13:0] exp;
    string       name;
  } vec_t;

  logic sys_clk;
  logic sys_rst_n;
  int unsigned n_checks;
  int unsigned n_errors;
  vec_t vecs[$];

  pll_lock_ctrl_if bus ();

  pll_lock_ctrl #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRY     (2)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .pll       (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic logic [13:0] pk(input logic a, input logic r, input logic o,
                                     input logic f, input logic [1:0] rt,
                                     input logic [7:0] lc);
    return {a, r, o, f, rt, lc};
  endfunction

  function automatic logic [13:0] outs();
    return {bus.pll_areset, bus.rst_n_out, bus.lock_ok, bus.pll_fail,
            bus.retry_cnt, bus.lost_cnt};
  endfunction

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got areset=%0b rst_n_out=%0b lock_ok=%0b pll_fail=%0b retry=%0d lost=%0d, expected areset=%0b rst_n_out=%0b lock_ok=%0b pll_fail=%0b retry=%0d lost=%0d",
               name, act[13], act[12], act[11], act[10], act[9:8], act[7:0],
               exp[13], exp[12], exp[11], exp[10], exp[9:8], exp[7:0]);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Release lands between edges, so the next posedge is edge 1.
  task automatic do_reset();
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic wait_rst(input logic v, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.rst_n_out === v) begin
        seen = 1'b1;
        break;
      end
      tick(1);
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL %s: rst_n_out=%0b after 60 cycles, expected %0b", name, bus.rst_n_out, v);
    end
  endtask

  task automatic add(input bit r, input logic lk, input int unsigned n,
                     input logic a, input logic rn, input logic o, input logic f,
                     input logic [1:0] rt, input logic [7:0] lc, input string name);
    vec_t v;
    v.do_rst = r;
    v.lk     = lk;
    v.n      = n;
    v.exp    = pk(a, rn, o, f, rt, lc);
    v.name   = name;
    vecs.push_back(v);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    sys_rst_n  = 1'b0;
    bus.locked = 1'b0;

    // nominal lock
    add(1, 0, 0, 1, 0, 0, 0, 0, 0, "s1 reset values");
    add(0, 0, 3, 1, 0, 0, 0, 0, 0, "s1 areset e3");
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, "s1 areset low e4");
    add(0, 0, 6, 0, 0, 0, 0, 0, 0, "s1 wait e10");
    add(0, 1, 2, 0, 0, 0, 0, 0, 0, "s1 sync e12");
    add(0, 1, 8, 0, 0, 0, 0, 0, 0, "s1 stable e20");
    add(0, 1, 1, 0, 1, 1, 0, 0, 0, "s1 run e21");
    // qualification glitch
    add(1, 0, 4, 0, 0, 0, 0, 0, 0, "s2 wait e4");
    add(0, 1, 7, 0, 0, 0, 0, 0, 0, "s2 stable e11");
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, "s2 glitch e12");
    add(0, 1, 3, 0, 0, 0, 0, 0, 0, "s2 requal e15");
    add(0, 1, 7, 0, 0, 0, 0, 0, 0, "s2 e22");
    add(0, 1, 1, 0, 1, 1, 0, 0, 0, "s2 run e23");
    // lock loss in RUN
    add(0, 0, 2, 0, 1, 1, 0, 0, 0, "s3 still run e25");
    add(0, 0, 1, 1, 0, 0, 0, 0, 1, "s3 lost e26");
    add(0, 1, 4, 0, 0, 0, 0, 0, 1, "s3 wait e30");
    add(0, 1, 8, 0, 0, 0, 0, 0, 1, "s3 e38");
    add(0, 1, 1, 0, 1, 1, 0, 0, 1, "s3 rerun e39");
    // total failure
    add(1, 0, 4, 0, 0, 0, 0, 0, 0, "s4 wait1 e4");
    add(0, 0, 19, 0, 0, 0, 0, 0, 0, "s4 e23");
    add(0, 0, 1, 1, 0, 0, 0, 1, 0, "s4 pulse2 e24");
    add(0, 0, 3, 1, 0, 0, 0, 1, 0, "s4 e27");
    add(0, 0, 1, 0, 0, 0, 0, 1, 0, "s4 wait2 e28");
    add(0, 0, 20, 1, 0, 0, 0, 2, 0, "s4 pulse3 e48");
    add(0, 0, 4, 0, 0, 0, 0, 2, 0, "s4 wait3 e52");
    add(0, 0, 19, 0, 0, 0, 0, 2, 0, "s4 e71");
    add(0, 0, 1, 1, 0, 0, 1, 2, 0, "s4 fail e72");
    add(0, 1, 20, 1, 0, 0, 1, 2, 0, "s4 fail sticky");
    // retry then success
    add(1, 0, 24, 1, 0, 0, 0, 1, 0, "s5 retry e24");
    add(0, 0, 6, 0, 0, 0, 0, 1, 0, "s5 wait2 e30");
    add(0, 1, 3, 0, 0, 0, 0, 1, 0, "s5 stable e33");
    add(0, 1, 7, 0, 0, 0, 0, 1, 0, "s5 e40");
    add(0, 1, 1, 0, 1, 1, 0, 0, 0, "s5 run e41");

    foreach (vecs[i]) begin
      bus.locked = vecs[i].lk;
      if (vecs[i].do_rst) do_reset();
      tick(vecs[i].n);
      check(vecs[i].name, outs(), vecs[i].exp);
    end

    // asynchronous reset from RUN with a nonzero loss count
    bus.locked = 1'b1;
    do_reset();
    tick(13);
    check("s6 run e13", outs(), pk(0, 1, 1, 0, 0, 0));
    bus.locked = 1'b0;
    wait_rst(1'b0, "s6 drop");
    bus.locked = 1'b1;
    wait_rst(1'b1, "s6 relock");
    check("s6 run lost1", outs(), pk(0, 1, 1, 0, 0, 1));
    #3;
    sys_rst_n = 1'b0;
    #1;
    check("s6 async rst in run", outs(), pk(1, 0, 0, 0, 0, 0));

    // asynchronous reset from FAIL
    bus.locked = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    tick(72);
    check("s6 fail e72", outs(), pk(1, 0, 0, 1, 2, 0));
    #3;
    sys_rst_n = 1'b0;
    #1;
    check("s6 async rst in fail", outs(), pk(1, 0, 0, 0, 0, 0));

    // loss counter saturation
    bus.locked = 1'b1;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    wait_rst(1'b1, "s6 sat first run");
    for (int k = 1; k <= 260; k++) begin
      int unsigned e0;
      e0 = n_errors;
      bus.locked = 1'b0;
      wait_rst(1'b0, "s6 sat drop");
      bus.locked = 1'b1;
      wait_rst(1'b1, "s6 sat relock");
      if (k == 1)   check("s6 lost 1", outs(), pk(0, 1, 1, 0, 0, 1));
      if (k == 254) check("s6 lost 254", outs(), pk(0, 1, 1, 0, 0, 254));
      if (k == 255) check("s6 lost 255", outs(), pk(0, 1, 1, 0, 0, 255));
      if (k == 260) check("s6 lost saturated", outs(), pk(0, 1, 1, 0, 0, 255));
      if (n_errors != e0) break;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pll_lock_ctrl.md
# pll_lock_ctrl

Sequencer for the board PLL. It holds the PLL in reset at power-up, waits for `locked` with a timeout and bounded retries, and requires `locked` to stay stable before releasing the reset for logic clocked by the PLL outputs. On loss of lock it re-arms the whole sequence. It runs on `sys_clk` and sits between the top level and the PLL instance: it drives the PLL `areset` and consumes the PLL `locked`.

## Interface
- `RST_CYCLES`, 16: cycles `pll_areset` is held high per reset attempt (≥1).
- `LOCK_TIMEOUT`, 50000: cycles to wait for lock per attempt (1 ms at 50 MHz, ≥2).
- `STABLE_CYCLES`, 1024: consecutive locked cycles required before release (≥1).
- `MAX_RETRY`, 3: re-attempts after the first timeout before declaring failure (1..3).

Ports (clock and reset first):
- `sys_clk` in 1: only clock.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `locked` in 1: PLL lock, asynchronous to `sys_clk`.
- `pll_areset` out 1: PLL reset, active-high.
- `rst_n_out` out 1: active-low reset for PLL-clocked logic. Each consuming domain re-synchronizes its release.
- `lock_ok` out 1: high only in RUN.
- `pll_fail` out 1: sticky failure flag.
- `retry_cnt` out 2: timeouts in the current bring-up.
- `lost_cnt` out 8: lock-loss events since `sys_rst_n`, saturates at 255.

## Operation
- `locked` passes through a 2-flop synchronizer (reset value 0) to give `locked_s`.
- One cycle counter, sized for `LOCK_TIMEOUT`, is cleared on every state change.
- Outputs are registered and decoded from the next state, so they change on the same edge as the state.
- States:
  - RESET: `pll_areset=1`, `rst_n_out=0`. After `RST_CYCLES` cycles go to WAIT_LOCK.
  - WAIT_LOCK: `pll_areset=0`. If `locked_s=1`, go to STABLE.
  - WAIT_LOCK timeout, counter reaches `LOCK_TIMEOUT-1`:
    - if `retry_cnt==MAX_RETRY`, go to FAIL;
    - otherwise `retry_cnt++` and go to RESET.
  - A lock in the same cycle as the timeout wins: go to STABLE.
  - STABLE: if `locked_s=0`, go to WAIT_LOCK with a fresh timeout. When the counter reaches `STABLE_CYCLES-1` with `locked_s=1`, go to RUN.
  - RUN: `rst_n_out=1`, `lock_ok=1`, `retry_cnt` cleared. If `locked_s=0`, `lost_cnt++` (saturating), go to RESET.
  - FAIL: `pll_areset=1`, `rst_n_out=0`, `pll_fail=1`. Terminal; only `sys_rst_n` exits.
- Reset values: state RESET, `pll_areset=1`, `rst_n_out=0`, `lock_ok=0`, `pll_fail=0`, `retry_cnt=0`, `lost_cnt=0`, synchronizer 0.
- Assertion of `sys_rst_n` in any state, including RUN and FAIL, returns immediately to the reset values. The sequence restarts from RESET.

## Timing
- `locked` first sampled high at edge E gives `locked_s` at E+1, STABLE at E+2, and RUN with `rst_n_out`↑ at E+2+`STABLE_CYCLES`.
- In RUN, `locked` sampled low at edge E gives `rst_n_out`↓, `pll_areset`↑ and `lost_cnt` increment at E+2.
- `pll_areset` pulse width is exactly `RST_CYCLES` cycles per attempt.
- Time to FAIL with no lock ever: (`MAX_RETRY`+1)×(`RST_CYCLES`+`LOCK_TIMEOUT`) cycles after reset release.
- Glitches shorter than one `sys_clk` period may be missed. Any sampled low in STABLE restarts qualification.

## Structure
- Shared package `pll_ctrl_pkg` holds:
  - the state encoding (RESET, WAIT_LOCK, STABLE, RUN, FAIL);
  - default parameter values;
  - the counter width function (clog2).
- Sub-module `sync_2ff` (1-bit, async active-low reset to 0) synchronizes `locked`. The same sub-module is reused elsewhere for other asynchronous status inputs.
- Everything else (FSM, counter, status registers) lives in one module.

## Test plan
All scenarios use `RST_CYCLES=4`, `LOCK_TIMEOUT=20`, `STABLE_CYCLES=8`, `MAX_RETRY=2`.
1. Nominal lock: release reset, raise `locked` 10 cycles later and hold. Required: `pll_areset` high for exactly 4 cycles after release; `rst_n_out`/`lock_ok` rise 10 edges after `locked` is first sampled; `retry_cnt=0`.
2. Qualification glitch: drop `locked` for 1 cycle, 5 cycles into STABLE. Required: back to WAIT_LOCK and qualification restarts; `rst_n_out` rises 10 edges after `locked` is re-sampled high.
3. Lock loss in RUN: drop `locked`. Required: `rst_n_out`↓ and `pll_areset`↑ 2 edges later; `lost_cnt=1`; on relock, RUN is reached again.
4. Total failure: keep `locked=0`. Required: 3 `pll_areset` pulses; `retry_cnt` reaches 2; `pll_fail=1` at cycle 72 with `pll_areset=1` held; `locked` asserted afterwards has no effect.
5. Retry then success: `locked` rises during the second attempt. Required: RUN reached with `retry_cnt=1` during STABLE; `retry_cnt` reads 0 once in RUN.
6. Mid-operation reset and saturation:
   - Assert `sys_rst_n` in RUN and in FAIL. Required: all outputs at reset values asynchronously.
   - Force 260 lock losses. Required: `lost_cnt` holds at 255.
